// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and state type for the SD command path
package sd_pkg;

    localparam int CMD_CONTENT_W = 38;
    localparam int CMD_TOKEN_W   = 48;
    localparam int NCC_MIN       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        TX     = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    localparam logic [CMD_CONTENT_W-1:0] CMD0_CONTENT = '0;
    localparam logic [5:0]               CMD17_INDEX  = 6'd17;

endpackage

// File: rtl/sd_rr_arb2.sv
// rtl/sd_rr_arb2.sv - two-way round-robin picker with a last-grant bit
module sd_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic win
);

    logic last_q;

    // On a tie the requester not granted last wins; a lone requester always wins.
    always_comb begin
        win = (valid0 && valid1) ? ~last_q : valid1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/sd_cmd_arb.sv
// rtl/sd_cmd_arb.sv - round-robin command scheduler in front of sd_send
module sd_cmd_arb
    import sd_pkg::*;
#(
    parameter int GAP_CYCLES    = 8,
    parameter int START_TIMEOUT = 64
) (
    input  logic                     sd_clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [CMD_CONTENT_W-1:0] req0_cmd,
    output logic                     req0_ready,
    output logic                     req0_done,
    input  logic                     req1_valid,
    input  logic [CMD_CONTENT_W-1:0] req1_cmd,
    output logic                     req1_ready,
    output logic                     req1_done,
    output logic                     send_en,
    output logic [CMD_CONTENT_W-1:0] cmd_content,
    input  logic                     sending,
    output logic                     busy,
    output logic                     grant_id,
    output logic                     err_timeout
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES);

    arb_state_t               state_q, state_d;
    logic [TW-1:0]            wcnt_q, wcnt_d, wcnt_inc;
    logic [GW-1:0]            gcnt_q, gcnt_d;
    logic                     send_en_d, gid_d, busy_d, err_d;
    logic                     r0_d, r1_d, d0_d, d1_d;
    logic [CMD_CONTENT_W-1:0] cmd_d;
    logic                     win, accept;

    sd_rr_arb2 u_rr (
        .clk    (sd_clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .win    (win)
    );

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        gcnt_d    = gcnt_q;
        send_en_d = send_en;
        cmd_d     = cmd_content;
        gid_d     = grant_id;
        r0_d      = 1'b0;
        r1_d      = 1'b0;
        d0_d      = 1'b0;
        d1_d      = 1'b0;
        err_d     = 1'b0;
        accept    = 1'b0;
        wcnt_inc  = (wcnt_q == T_LAST) ? wcnt_q : wcnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                // The done cycle is never an acceptance edge, so the next ready
                // lands GAP_CYCLES+2 after done even when there is no GAP state.
                if ((req0_valid || req1_valid) && !(req0_done || req1_done)) begin
                    accept    = 1'b1;
                    cmd_d     = win ? req1_cmd : req0_cmd;
                    gid_d     = win;
                    r0_d      = ~win;
                    r1_d      = win;
                    send_en_d = 1'b1;
                    wcnt_d    = '0;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                if (sending) begin
                    send_en_d = 1'b0;
                    state_d   = TX;
                end else begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == T_LAST) begin
                        send_en_d = 1'b0;
                        err_d     = 1'b1;
                        d0_d      = ~grant_id;
                        d1_d      = grant_id;
                        gcnt_d    = '0;
                        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
            end
            TX: begin
                if (!sending) begin
                    d0_d    = ~grant_id;
                    d1_d    = grant_id;
                    gcnt_d  = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gcnt_q == G_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sd_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            send_en     <= 1'b0;
            cmd_content <= '0;
            grant_id    <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            send_en     <= send_en_d;
            cmd_content <= cmd_d;
            grant_id    <= gid_d;
            req0_ready  <= r0_d;
            req1_ready  <= r1_d;
            req0_done   <= d0_d;
            req1_done   <= d1_d;
            err_timeout <= err_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_sd_cmd_arb.sv
// tb/tb_sd_cmd_arb.sv - bench for sd_cmd_arb with GAP_CYCLES=8 and GAP_CYCLES=0 builds
module tb_sd_cmd_arb;
    import sd_pkg::*;

    localparam int TO = 64;

    logic        sd_clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [37:0] req0_cmd, req1_cmd;
    logic        sending = 1'b0;
    logic        sel;

    logic        a_r0, a_r1, a_d0, a_d1, a_se, a_busy, a_gid, a_err;
    logic [37:0] a_cmd;
    logic        b_r0, b_r1, b_d0, b_d1, b_se, b_busy, b_gid, b_err;
    logic [37:0] b_cmd;

    logic        o_r0, o_r1, o_d0, o_d1, o_se, o_busy, o_gid, o_err;
    logic [37:0] o_cmd;

    always #5 sd_clk = ~sd_clk;

    sd_cmd_arb #(.GAP_CYCLES(8), .START_TIMEOUT(TO)) dut_a (
        .sd_clk(sd_clk), .reset(reset),
        .req0_valid(req0_valid & ~sel), .req0_cmd(req0_cmd), .req0_ready(a_r0), .req0_done(a_d0),
        .req1_valid(req1_valid & ~sel), .req1_cmd(req1_cmd), .req1_ready(a_r1), .req1_done(a_d1),
        .send_en(a_se), .cmd_content(a_cmd), .sending(sending),
        .busy(a_busy), .grant_id(a_gid), .err_timeout(a_err)
    );

    sd_cmd_arb #(.GAP_CYCLES(0), .START_TIMEOUT(TO)) dut_b (
        .sd_clk(sd_clk), .reset(reset),
        .req0_valid(req0_valid & sel), .req0_cmd(req0_cmd), .req0_ready(b_r0), .req0_done(b_d0),
        .req1_valid(req1_valid & sel), .req1_cmd(req1_cmd), .req1_ready(b_r1), .req1_done(b_d1),
        .send_en(b_se), .cmd_content(b_cmd), .sending(sending),
        .busy(b_busy), .grant_id(b_gid), .err_timeout(b_err)
    );

    assign o_r0   = sel ? b_r0   : a_r0;
    assign o_r1   = sel ? b_r1   : a_r1;
    assign o_d0   = sel ? b_d0   : a_d0;
    assign o_d1   = sel ? b_d1   : a_d1;
    assign o_se   = sel ? b_se   : a_se;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_gid  = sel ? b_gid  : a_gid;
    assign o_err  = sel ? b_err  : a_err;
    assign o_cmd  = sel ? b_cmd  : a_cmd;

    // sd_send stand-in: sending rises once send_en has been seen send_delay cycles
    int send_delay = 3, send_len = 48, se_cnt = 0, tx_cnt = 0;
    bit no_send = 0, hold_sending = 0, was_held = 0;

    always @(negedge sd_clk) begin
        if (hold_sending) begin
            sending  = 1'b1;
            was_held = 1'b1;
        end else if (was_held) begin
            sending  = 1'b0;
            was_held = 1'b0;
            se_cnt   = 0;
            tx_cnt   = 0;
        end else if (sending) begin
            tx_cnt++;
            if (tx_cnt >= send_len) sending = 1'b0;
        end else if (o_se && !no_send) begin
            se_cnt++;
            if (se_cnt >= send_delay) begin
                sending = 1'b1;
                se_cnt  = 0;
                tx_cnt  = 0;
            end
        end else begin
            se_cnt = 0;
        end
    end

    int tests = 0, fails = 0;
    int last_grant = 1;
    int gap = 8;
    int wait_cyc;

    task automatic tick();
        @(negedge sd_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] rand_cmd();
        return {6'($urandom_range(0, 63)), $urandom()};
    endfunction

    task automatic wait_ready(output bit got);
        got = 0;
        for (wait_cyc = 1; wait_cyc <= 200; wait_cyc++) begin
            tick();
            if (o_r0 || o_r1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $error("FAIL ready_wait observed=no_ready expected=ready_within_200");
        end
    endtask

    // One full command life: acceptance, launch, transfer or timeout, gap, back to idle.
    task automatic serve(input int d, input int len, input bit tmo,
                         input bit keep0, input bit keep1, output int id);
        int          dk;
        bit          got;
        logic [37:0] ecmd;
        logic [45:0] e, o;
        send_delay = d;
        send_len   = len;
        no_send    = tmo;
        id   = (req0_valid && req1_valid) ? 1 - last_grant : (req1_valid ? 1 : 0);
        ecmd = id ? req1_cmd : req0_cmd;
        wait_ready(got);
        if (!got) return;
        last_grant = id;
        dk = tmo ? TO : d + len;
        for (int k = 0; k <= dk + gap + 1; k++) begin
            if (k > 0) tick();
            e = {(k < (tmo ? TO : d)), (k == 0 && id == 0), (k == 0 && id == 1),
                 (k == dk && id == 0), (k == dk && id == 1), (tmo && k == dk),
                 (k < dk + gap + ((gap > 0) ? 1 : 0)), 1'(id), ecmd};
            o = {o_se, o_r0, o_r1, o_d0, o_d1, o_err, o_busy, o_gid, o_cmd};
            chk($sformatf("cmd_cycle%0d", k), 64'(o), 64'(e));
            if (k == 0) begin
                if (id == 0) begin
                    if (keep0) req0_cmd = rand_cmd(); else req0_valid = 1'b0;
                end else begin
                    if (keep1) req1_cmd = rand_cmd(); else req1_valid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  id, prev;
        bit  got;
        reset = 1'b0;
        sel = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_cmd = '0;
        req1_cmd = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("reset_state", 64'({o_se, o_r0, o_r1, o_d0, o_d1, o_err, o_busy, o_gid, o_cmd}), 64'(0));

        // Single CMD0 from the init controller
        req0_cmd = CMD0_CONTENT;
        req0_valid = 1'b1;
        serve(3, 48, 0, 0, 0, id);
        chk("cmd0_latency", 64'(wait_cyc), 64'(1));

        // Tie right after reset: req0 first, then CMD17 GAP+2 after done
        reset = 1'b0;
        tick();
        reset = 1'b1;
        last_grant = 1;
        tick();
        req0_cmd = CMD0_CONTENT;
        req1_cmd = {CMD17_INDEX, 32'h0};
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        serve(3, 10, 0, 0, 0, id);
        chk("tie_first", 64'(id), 64'(0));
        serve(2, 6, 0, 0, 0, id);
        chk("tie_second_latency", 64'(wait_cyc), 64'(1));
        chk("tie_cmd17", 64'(o_cmd), 64'(38'h11_0000_0000));

        // Both requesters busy: grants must alternate
        req0_cmd = rand_cmd();
        req1_cmd = rand_cmd();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        prev = last_grant;
        for (int i = 0; i < 4; i++) begin
            serve($urandom_range(1, 5), $urandom_range(2, 12), 0, 1, 1, id);
            chk($sformatf("rr_alt%0d", i), 64'(id), 64'(1 - prev));
            chk($sformatf("rr_latency%0d", i), 64'(wait_cyc), 64'(1));
            prev = id;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // sd_send never starts: timeout after START_TIMEOUT cycles of send_en
        req1_cmd = rand_cmd();
        req1_valid = 1'b1;
        serve(1, 1, 1, 0, 0, id);
        no_send = 0;

        // Reset during a transfer with sending stuck high
        req0_cmd = rand_cmd();
        req0_valid = 1'b1;
        send_delay = 2;
        send_len = 48;
        wait_ready(got);
        chk("mid_grant", 64'({o_r0, o_r1}), 64'(2'b10));
        last_grant = 0;
        req0_valid = 1'b0;
        repeat (10) tick();
        hold_sending = 1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        last_grant = 1;
        chk("mid_reset_outputs", 64'({o_se, o_r0, o_r1, o_d0, o_d1, o_err, o_busy, o_gid, o_cmd}), 64'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mid_ignore%0d", i),
                64'({o_se, o_r0, o_r1, o_d0, o_d1, o_err, o_busy, o_gid, o_cmd}), 64'(0));
        end
        hold_sending = 0;
        repeat (3) tick();
        req0_cmd = rand_cmd();
        req1_cmd = rand_cmd();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        serve(2, 5, 0, 0, 0, id);
        chk("post_reset_tie", 64'(id), 64'(0));
        serve(3, 5, 0, 0, 0, id);
        chk("post_reset_req1", 64'(id), 64'(1));

        // GAP_CYCLES=0 build: back-to-back commands from req1
        sel = 1'b1;
        gap = 0;
        tick();
        req1_cmd = rand_cmd();
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve($urandom_range(1, 4), $urandom_range(2, 8), 0, 0, (i < 2), id);
            chk($sformatf("gap0_latency%0d", i), 64'(wait_cyc), 64'(1));
            chk($sformatf("gap0_id%0d", i), 64'(id), 64'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
